// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM encoding, default base address and address decode functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

    function automatic logic [31:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr - base) >> 2;
    endfunction

    // Limit is formed in 33 bits so a segment ending at 4 GiB cannot wrap.
    function automatic logic addr_fault(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [32:0] lim;
        lim = {1'b0, base} + (33'(depth) << 2);
        return (addr[1:0] != 2'b00)
            || (addr < base)
            || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port 32-bit word RAM with per-byte write enables.
// Read data is registered on every enabled edge and held otherwise.
module dmem_word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request/response with wait states,
// byte-enable stores and fault reporting for bad addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit          DIRECT    = (WAIT_CYCLES == 0);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic          req_fault;
    logic          accept;
    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    assign req_fault = addr_fault(req_addr, BASE_ADDR, DEPTH_WORDS);
    assign accept    = (state_q == IDLE) && req_valid;

    // The RAM is touched only on the edge that enters RESP; with no wait
    // states that edge is the accepting one, so the live request is used.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = write_q;
        ram_be    = be_q;
        ram_addr  = AW'(word_index(addr_q, BASE_ADDR));
        ram_wdata = wdata_q;
        if (!reset) begin
            if (DIRECT && accept) begin
                ram_en    = !req_fault;
                ram_we    = req_write;
                ram_be    = req_be;
                ram_addr  = AW'(word_index(req_addr, BASE_ADDR));
                ram_wdata = req_wdata;
            end else if ((state_q == WAIT) && (cnt_q == 4'd1)) begin
                ram_en = !err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        err_q       <= req_fault;
                        req_ready_q <= 1'b0;
                        if (DIRECT) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            cnt_q        <= 4'd0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        cnt_q        <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= 4'd0;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q && err_q;
    assign resp_rdata = (resp_valid_q && !write_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states)
// checked against an address-keyed reference memory.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] SPAN = 32'd4096;

    logic        clk;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int total;
    int bad;
    logic [31:0] model [int];

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_be    (req_be[0]),
        .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]),
        .resp_err  (resp_err[0])
    );

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_be    (req_be[1]),
        .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]),
        .resp_err  (resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a < BASE) || (a >= BASE + SPAN);
    endfunction

    function automatic int key_of(input int d, input logic [31:0] a);
        return d * 65536 + int'((a - BASE) / 4);
    endfunction

    // One full transaction; expectations come from the caller.
    task automatic xact(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int hold, input logic [31:0] exp_rd,
                        input logic exp_er, output logic [31:0] rd);
        int n;
        int lat;
        int wc;
        wc = (d == 0) ? 2 : 0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        req_be[d]     = be;
        resp_ready[d] = 1'b0;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
        chk("ready_busy", 32'(req_ready[d]), 32'd0);
        lat = 1;
        while (!resp_valid[d] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 1 + wc);
        chk("rdata", resp_rdata[d], exp_rd);
        chk("err", 32'(resp_err[d]), 32'(exp_er));
        rd = resp_rdata[d];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid[d]), 32'd1);
            chk("hold_rdata", resp_rdata[d], exp_rd);
            chk("hold_err", 32'(resp_err[d]), 32'(exp_er));
            chk("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        chk("valid_drop", 32'(resp_valid[d]), 32'd0);
        chk("ready_back", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic op(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input int hold, output logic [31:0] rd);
        logic        er;
        logic [31:0] exp_rd;
        logic [31:0] cur;
        int          k;
        er     = is_fault(a);
        exp_rd = 32'd0;
        k      = 0;
        if (!er) begin
            k = key_of(d, a);
            if (!wr) exp_rd = model[k];
        end
        xact(d, wr, a, wd, be, hold, exp_rd, er, rd);
        if (wr && !er) begin
            cur = model.exists(k) ? model[k] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
            model[k] = cur;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int cnt;
        int r;
        total = 0;
        bad   = 0;
        for (int d = 0; d < 2; d++) begin
            reset[d]      = 1'b1;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            req_be[d]     = '0;
            resp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
        end

        op(0, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, 0, rd);
        op(0, 1'b0, BASE, 32'h0, 4'h0, 0, rd);
        chk("raw_word0", rd, 32'hDEAD_BEEF);

        op(0, 1'b1, BASE + 4, 32'h1122_3344, 4'hF, 0, rd);
        op(0, 1'b1, BASE + 4, 32'hAABB_CCDD, 4'b0101, 0, rd);
        op(0, 1'b0, BASE + 4, 32'h0, 4'hF, 0, rd);
        chk("byte_merge", rd, 32'h11BB_33DD);
        op(0, 1'b1, BASE + 4, 32'hFFFF_FFFF, 4'b0000, 0, rd);
        op(0, 1'b0, BASE + 4, 32'h0, 4'h0, 0, rd);
        chk("be_zero", rd, 32'h11BB_33DD);

        op(0, 1'b0, BASE + 2, 32'h0, 4'hF, 0, rd);
        op(0, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, 0, rd);
        op(0, 1'b1, 32'h1001_1000, 32'h5555_5555, 4'hF, 0, rd);
        op(0, 1'b1, 32'h1001_0FFD, 32'h6666_6666, 4'hF, 0, rd);
        op(0, 1'b0, BASE, 32'h0, 4'hF, 0, rd);
        chk("fault_no_write", rd, 32'hDEAD_BEEF);
        op(0, 1'b0, 32'h1001_0FFC, 32'h0, 4'hF, 0, rd);

        op(0, 1'b0, BASE + 4, 32'h0, 4'hF, 5, rd);

        op(0, 1'b1, BASE + 8, 32'hCAFE_F00D, 4'hF, 0, rd);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = BASE + 8;
        req_wdata[0] = 32'h1234_5678;
        req_be[0]    = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset[0] = 1'b1;
        @(posedge clk); #1;
        reset[0] = 1'b0;
        chk("midrst_ready", 32'(req_ready[0]), 32'd1);
        chk("midrst_valid", 32'(resp_valid[0]), 32'd0);
        chk("midrst_rdata", resp_rdata[0], 32'd0);
        chk("midrst_err", 32'(resp_err[0]), 32'd0);
        op(0, 1'b0, BASE + 8, 32'h0, 4'hF, 0, rd);
        chk("midrst_keep", rd, 32'hCAFE_F00D);

        reset[0]     = 1'b1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = BASE + 8;
        req_wdata[0] = 32'h0BAD_0BAD;
        req_be[0]    = 4'hF;
        @(posedge clk); #1;
        reset[0]     = 1'b0;
        req_valid[0] = 1'b0;
        chk("rstreq_ready", 32'(req_ready[0]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rstreq_valid", 32'(resp_valid[0]), 32'd0);
        op(0, 1'b0, BASE + 8, 32'h0, 4'hF, 0, rd);
        chk("rstreq_keep", rd, 32'hCAFE_F00D);

        op(1, 1'b1, BASE, 32'h5A5A_0001, 4'hF, 0, rd);
        op(1, 1'b0, BASE, 32'h0, 4'hF, 0, rd);
        op(1, 1'b0, BASE + 1, 32'h0, 4'hF, 2, rd);
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b0;
        req_addr[1]   = BASE;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid[1]) begin
                cnt++;
                chk("tput_rdata", resp_rdata[1], 32'h5A5A_0001);
            end
        end
        req_valid[1] = 1'b0;
        chk("tput_count", cnt, 10);
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        chk("tput_idle", 32'(req_ready[1]), 32'd1);

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                op(d, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 0, rd);
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            unique case (r)
                0: a = BASE + 32'(4 * $urandom_range(0, 15))
                       + 32'($urandom_range(1, 3));
                1: a = BASE - 32'(4 * $urandom_range(1, 8));
                2: a = BASE + SPAN + 32'(4 * $urandom_range(0, 8));
                default: a = BASE + 32'(4 * $urandom_range(0, 15));
            endcase
            op(i % 2, 1'($urandom), a, $urandom, 4'($urandom),
               int'($urandom_range(0, 3)), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
